pattern_tx: RTL and testbench

Serial pattern transmitter for the 2-bit code sequence detector. It accepts a 2-bit code from a parallel request interface and shifts out, one bit per clock, the bit pattern that makes the detector report that same code. It sits on the transmit side of the single-wire serial link; its `out` drives the detector's `inp`, directly or through the link.

---
 rtl/pattern_pkg.sv | 36 +++
 rtl/pattern_tx.sv | 99 +++++++++
 tb/tb_pattern_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// ============================================================================
// pattern_pkg : code constants, transmitter state encoding and ones-count helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pattern_pkg;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_SHORT = 2'b01;
    localparam logic [1:0] CODE_MID   = 2'b10;
    localparam logic [1:0] CODE_LONG  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LEAD = 2'd1;
    localparam logic [1:0] ST_ONES = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    localparam int unsigned CNT_W = 4;

    // Number of 1s in the frame body for a given code
    function automatic logic [CNT_W-1:0] ones_for_code(
        input logic [1:0]  code,
        input int unsigned long_ones
    );
        case (code)
            CODE_SHORT: ones_for_code = CNT_W'(1);
            CODE_MID:   ones_for_code = CNT_W'(2);
            CODE_LONG:  ones_for_code = CNT_W'(long_ones);
            default:    ones_for_code = '0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_tx.sv
// ============================================================================
// pattern_tx : serial frame transmitter (0, N ones, 0) for the 2-bit detector.
//              Optional frame counter enabled by PATTERN_TX_FRAME_CNT_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module pattern_tx
    import pattern_pkg::*;
#(
    parameter int unsigned LONG_ONES = 3
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] code,
    input  logic       start,
    output logic       ready,
    output logic       out,
    output logic       done,
    output logic       err
`ifdef PATTERN_TX_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_err;

    logic [1:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_ready;
    logic             w_accept;

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_TAIL);
    assign w_accept = start && w_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_TAIL: begin
                // A code-00 request falls through to IDLE; only err reacts
                if (w_accept && (code != CODE_NONE)) begin
                    w_nxt_state = ST_LEAD;
                    w_nxt_cnt   = ones_for_code(code, LONG_ONES);
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_LEAD: w_nxt_state = ST_ONES;
            ST_ONES: begin
                w_nxt_cnt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_nxt_state = ST_TAIL;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_out   <= (w_nxt_state == ST_ONES);
            r_err   <= w_accept && (code == CODE_NONE);
        end
    end

    assign ready = w_ready;
    assign out   = r_out;
    assign done  = (r_state == ST_TAIL);
    assign err   = r_err;

`ifdef PATTERN_TX_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (r_state == ST_TAIL) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_tx.sv
// ============================================================================
// tb_pattern_tx : randomized + directed bench for pattern_tx (LONG_ONES 3 and 15)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] code = 2'b00;

    logic [1:0] ready_v, out_v, done_v, err_v;
`ifdef PATTERN_TX_FRAME_CNT_EN
    logic [7:0] fcnt_v [2];
`endif

    always #5 clk = ~clk;

    pattern_tx #(.LONG_ONES(3)) u_dut_s (
        .clk   (clk),
        .rst   (rst),
        .code  (code),
        .start (start),
        .ready (ready_v[0]),
        .out   (out_v[0]),
        .done  (done_v[0]),
        .err   (err_v[0])
`ifdef PATTERN_TX_FRAME_CNT_EN
        ,
        .frame_cnt (fcnt_v[0])
`endif
    );

    pattern_tx #(.LONG_ONES(15)) u_dut_l (
        .clk   (clk),
        .rst   (rst),
        .code  (code),
        .start (start),
        .ready (ready_v[1]),
        .out   (out_v[1]),
        .done  (done_v[1]),
        .err   (err_v[1])
`ifdef PATTERN_TX_FRAME_CNT_EN
        ,
        .frame_cnt (fcnt_v[1])
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: frame position bookkeeping plus a loopback run-length decoder
    int         c_long [2] = '{3, 15};
    bit         m_act  [2];
    int         m_pos  [2];
    int         m_n    [2];
    bit         m_err  [2];
    int         m_fc   [2];
    int         run    [2];
    logic [1:0] sent   [2][4096];
    int         wr     [2];
    int         rd     [2];

    task automatic step(input logic r, input logic s, input logic [1:0] c);
        bit ed [2];
        bit er [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit         eo;
            logic [1:0] dec;
            ed[i] = m_act[i] && (m_pos[i] == m_n[i] + 1);
            eo    = m_act[i] && (m_pos[i] >= 1) && (m_pos[i] <= m_n[i]);
            er[i] = !m_act[i] || ed[i];
            check($sformatf("out%0d", i),  int'(out_v[i]),   int'(eo));
            check($sformatf("done%0d", i), int'(done_v[i]),  int'(ed[i]));
            check($sformatf("rdy%0d", i),  int'(ready_v[i]), int'(er[i]));
            check($sformatf("err%0d", i),  int'(err_v[i]),   int'(m_err[i]));
`ifdef PATTERN_TX_FRAME_CNT_EN
            check($sformatf("fcnt%0d", i), int'(fcnt_v[i]),  m_fc[i]);
`endif
            if (out_v[i] === 1'b1) begin
                run[i]++;
            end else if (run[i] > 0) begin
                if (run[i] == 1)              dec = 2'b01;
                else if (run[i] == 2)         dec = 2'b10;
                else if (run[i] == c_long[i]) dec = 2'b11;
                else                          dec = 2'b00;
                if (rd[i] == wr[i]) begin
                    check($sformatf("dec_spurious%0d", i), int'(dec), 0);
                end else begin
                    check($sformatf("dec%0d", i), int'(dec), int'(sent[i][rd[i] % 4096]));
                    rd[i]++;
                end
                run[i] = 0;
            end
        end

        rst   = r;
        start = s;
        code  = c;

        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = er[i] && s;
            if (!r) begin
                m_act[i] = 1'b0;
                m_err[i] = 1'b0;
                m_fc[i]  = 0;
                run[i]   = 0;
                rd[i]    = wr[i];
            end else begin
                if (ed[i]) m_fc[i] = (m_fc[i] + 1) % 256;
                m_err[i] = acc && (c == 2'b00);
                if (m_act[i] && !ed[i]) begin
                    m_pos[i]++;
                end else begin
                    m_act[i] = 1'b0;
                    if (acc && (c != 2'b00)) begin
                        m_act[i] = 1'b1;
                        m_pos[i] = 0;
                        m_n[i]   = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : c_long[i];
                        sent[i][wr[i] % 4096] = c;
                        wr[i]++;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_pos[i] = 0; m_n[i] = 0; m_err[i] = 1'b0;
            m_fc[i]  = 0;    run[i]   = 0; wr[i]  = 0; rd[i]    = 0;
        end
        repeat (2) @(posedge clk);

        // Idle after reset
        repeat (10) step(1'b1, 1'b0, 2'b00);

        // Single frames from IDLE
        for (int c = 1; c <= 3; c++) begin
            step(1'b1, 1'b1, 2'(c));
            repeat (20) step(1'b1, 1'b0, 2'b00);
        end

        // Back-to-back long frames
        repeat (15) step(1'b1, 1'b1, 2'b11);
        repeat (20) step(1'b1, 1'b0, 2'b00);

        // Code 00 request
        step(1'b1, 1'b1, 2'b00);
        repeat (5) step(1'b1, 1'b0, 2'b00);

        // Reset during the ones phase, then a short frame
        step(1'b1, 1'b1, 2'b11);
        repeat (3) step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 2'b01);
        repeat (20) step(1'b1, 1'b0, 2'b00);

        // 256 short frames to wrap the frame counter
        repeat (768) step(1'b1, 1'b1, 2'b01);
        repeat (20) step(1'b1, 1'b0, 2'b00);

        // Random traffic with occasional resets
        repeat (3000) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)));
        end
        repeat (20) step(1'b1, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
